// File: rtl/program_loader_pkg.sv
// Shared constants, state encoding and the length-legality helper
// for the instruction-memory program loader.
package program_loader_pkg;

   localparam int DEPTH   = 16;
   localparam int AW      = 4;
   localparam int DW      = 8;
   localparam int LEN_MAX = 16;
   localparam int LEN_W   = 5;
   localparam int CSUM_W  = 8;

   typedef logic [2:0] state_t;

   localparam state_t ST_CLEAR = 3'd0;
   localparam state_t ST_IDLE  = 3'd1;
   localparam state_t ST_LEN   = 3'd2;
   localparam state_t ST_DATA  = 3'd3;
   localparam state_t ST_SUM   = 3'd4;
   localparam state_t ST_DONE  = 3'd5;
   localparam state_t ST_ERR   = 3'd6;

   // A length byte is usable only if it names 1..LEN_MAX instructions.
   function automatic logic len_ok(input logic [DW-1:0] b);
      return (b != '0) && (b <= DW'(LEN_MAX));
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// Valid/ready byte stream feeding the loader; the producer is the master.
interface program_loader_if;
   import program_loader_pkg::*;

   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;

   modport master (output in_valid, output in_data, input  in_ready);
   modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/program_loader_ram.sv
// Instruction store: one synchronous write port, one combinational read port
// so the CPU can fetch asynchronously from its PC.
module prog_ram
   import program_loader_pkg::*;
(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Framed program loader: CLEAR wipes the store, then LEN/DATA/SUM accept a
// length, instruction bytes and a mod-256 checksum; the CPU is released only in DONE.
module program_loader
   import program_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   program_loader_if.slave   bus,
   input  logic [AW-1:0]     cpu_addr,
   output logic [DW-1:0]     cpu_inst,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t             state;
   logic               load_req;
   logic [LEN_W-1:0]   len;
   logic [AW:0]        wptr;
   logic [AW:0]        wptr_next;
   logic [CSUM_W-1:0]  sum;
   logic [AW-1:0]      clr_ptr;

   logic               in_stream;
   logic               xfer;
   logic               ram_we;
   logic [AW-1:0]      ram_waddr;
   logic [DW-1:0]      ram_wdata;

   // start wins over any handshake, so the stream is throttled in its cycle.
   assign in_stream   = (state == ST_LEN) || (state == ST_DATA) || (state == ST_SUM);
   assign bus.in_ready = in_stream && !start;
   assign xfer        = bus.in_valid && bus.in_ready;
   assign wptr_next   = wptr + 1'b1;

   assign cpu_rst = (state != ST_DONE);
   assign busy    = (state == ST_CLEAR) || in_stream;
   assign done    = (state == ST_DONE);
   assign err     = (state == ST_ERR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_CLEAR;
         load_req <= 1'b0;
         clr_ptr  <= '0;
         sum      <= '0;
         wptr     <= '0;
         len      <= '0;
      end else if (start) begin
         state    <= ST_CLEAR;
         load_req <= 1'b1;
         clr_ptr  <= '0;
         sum      <= '0;
         wptr     <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               clr_ptr <= clr_ptr + 1'b1;
               if (clr_ptr == AW'(DEPTH - 1)) begin
                  state    <= load_req ? ST_LEN : ST_IDLE;
                  load_req <= 1'b0;
               end
            end
            ST_LEN: begin
               if (xfer) begin
                  if (len_ok(bus.in_data)) begin
                     len   <= bus.in_data[LEN_W-1:0];
                     state <= ST_DATA;
                  end else begin
                     state <= ST_ERR;
                  end
               end
            end
            ST_DATA: begin
               if (xfer) begin
                  sum  <= sum + bus.in_data;
                  wptr <= wptr_next;
                  if (wptr_next == len) begin
                     state <= ST_SUM;
                  end
               end
            end
            ST_SUM: begin
               if (xfer) begin
                  state <= (bus.in_data == sum) ? ST_DONE : ST_ERR;
               end
            end
            ST_IDLE, ST_DONE, ST_ERR: begin
               state <= state;
            end
            default: begin
               state <= ST_CLEAR;
            end
         endcase
      end
   end

   // The single write port is shared: zero-fill while clearing, stream bytes in DATA.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = wptr[AW-1:0];
      ram_wdata = bus.in_data;
      if (!rst && state == ST_CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_ptr;
         ram_wdata = '0;
      end else if (!rst && state == ST_DATA && xfer) begin
         ram_we    = 1'b1;
      end
   end

   prog_ram u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (cpu_addr),
      .rdata (cpu_inst)
   );

endmodule
